// File: rtl/seq_scan_ctrl_if.sv
// rtl/seq_scan_ctrl_if.sv - byte stream into the 1101 scan controller
interface seq_scan_ctrl_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/seq_scan_ctrl.sv
// rtl/seq_scan_ctrl.sv - frames bytes MSB-first onto a 1101 detector and tallies hits
module seq_scan_ctrl #(
  parameter int LEN_W = 8,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [LEN_W-1:0]   len_i,
  seq_scan_ctrl_if.slave     in_if,
  output logic               det_rst_o,
  output logic               det_din_o,
  input  logic               det_y_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic [CNT_W-1:0]   hit_count_o,
  output logic               hit_seen_o,
  output logic [LEN_W+2:0]   first_hit_pos_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   acc_q, acc_d;
  logic [7:0]         sr_q, sr_d;
  logic [7:0]         hold_q, hold_d;
  logic               hold_full_q, hold_full_d;
  logic [LEN_W+2:0]   pos_q, pos_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               seen_q, seen_d;
  logic [LEN_W+2:0]   first_q, first_d;
  logic               in_ready;
  logic               det_rst;
  logic               det_din;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      acc_q       <= '0;
      sr_q        <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      pos_q       <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      seen_q      <= 1'b0;
      first_q     <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      acc_q       <= acc_d;
      sr_q        <= sr_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      pos_q       <= pos_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      seen_q      <= seen_d;
      first_q     <= first_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    acc_d       = acc_q;
    sr_d        = sr_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    pos_d       = pos_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    seen_d      = seen_q;
    first_d     = first_q;
    in_ready    = 1'b0;
    det_rst     = 1'b1;
    det_din     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          len_d   = len_i;
          cnt_d   = '0;
          seen_d  = 1'b0;
          first_d = '0;
          err_d   = 1'b0;
          state_d = (len_i == '0) ? ST_DONE : ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (abort_i) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        if (abort_i) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (in_if.in_valid) begin
          sr_d        = in_if.in_data;
          pos_d       = '0;
          acc_d       = {{(LEN_W-1){1'b0}}, 1'b1};
          hold_full_d = 1'b0;
          state_d     = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        det_rst  = 1'b0;
        det_din  = sr_q[7];
        in_ready = !hold_full_q && (acc_q < len_q);
        if (abort_i) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          sr_d  = {sr_q[6:0], 1'b0};
          pos_d = pos_q + 1'b1;
          if (in_ready && in_if.in_valid) begin
            hold_d      = in_if.in_data;
            hold_full_d = 1'b1;
            acc_d       = acc_q + 1'b1;
          end
          if (det_y_i) begin
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            if (!seen_q) begin
              seen_d  = 1'b1;
              first_d = pos_q;
            end
          end
          // Only a byte already held before bit 7 can follow without a bubble.
          if (pos_q[2:0] == 3'd7) begin
            if (hold_full_q) begin
              sr_d        = hold_q;
              hold_full_d = 1'b0;
            end else if (acc_q == len_q) begin
              state_d = ST_DONE;
            end else begin
              err_d   = 1'b1;
              state_d = ST_DONE;
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign in_if.in_ready  = in_ready;
  assign det_rst_o       = det_rst;
  assign det_din_o       = det_din;
  assign busy_o          = (state_q != ST_IDLE);
  assign done_o          = (state_q == ST_DONE);
  assign err_o           = err_q;
  assign hit_count_o     = cnt_q;
  assign hit_seen_o      = seen_q;
  assign first_hit_pos_o = first_q;

endmodule
